// File: rtl/bfm_ahbl_apb_bridge_mc.sv
// AHB-Lite slave to multi-channel APB3 master bridge; slot index taken from HADDR[SLOT_LSB+3:SLOT_LSB].
// Optional APB_TIMEOUT_EN adds an ACCESS wait limit of TIMEOUT_CYCLES; TPD is carried for harness compatibility only.
module bfm_ahbl_apb_bridge_mc #(
  parameter int NUM_SLAVES     = 16,
  parameter int SLOT_LSB       = 8,
  parameter int PADDR_W        = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TPD            = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [31:0]             HADDR,
  input  logic                    HWRITE,
  input  logic [1:0]              HTRANS,
  input  logic [2:0]              HSIZE,
  input  logic [31:0]             HWDATA,
  input  logic                    HREADYIN,
  output logic [31:0]             HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [PADDR_W-1:0]      PADDR,
  output logic [NUM_SLAVES-1:0]   PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]   PREADY,
  input  logic [NUM_SLAVES-1:0]   PSLVERR
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || PADDR_W < 1 || PADDR_W > 32 ||
      SLOT_LSB < 0 || SLOT_LSB > 28 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
      TPD < 0) begin : g_bad_params
    $error("bfm_ahbl_apb_bridge_mc: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_DPHASE, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2
  } state_t;

  state_t               state_q, state_d;
  logic [PADDR_W-1:0]   paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [3:0]           idx_q, idx_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [31:0]          hrdata_q, hrdata_d;

  logic                 accept;
  logic [3:0]           idx_in;
  logic                 legal_in;
  logic [31:0]          sel_prdata;
  logic                 sel_pready;
  logic                 sel_pslverr;
  logic                 timeout_hit;
  logic                 psel_en;

  assign accept   = HSEL & HREADYIN & HTRANS[1];
  assign idx_in   = HADDR[SLOT_LSB+3:SLOT_LSB];
  assign legal_in = ({1'b0, idx_in} < 5'(NUM_SLAVES)) && (HSIZE <= 3'b010);

  always_comb begin
    sel_prdata  = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        sel_prdata  = PRDATA[32*i +: 32];
        sel_pready  = PREADY[i];
        sel_pslverr = PSLVERR[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_SETUP)
      tmo_cnt_d = '0;
    else if (state_q == ST_ACCESS && !sel_pready)
      tmo_cnt_d = tmo_cnt_q + 16'd1;
  end

  assign timeout_hit = (state_q == ST_ACCESS) && !sel_pready &&
                       (tmo_cnt_d == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Only IDLE accepts; a transfer shown during ERR2 is cancelled by the master.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!legal_in)   state_d = ST_ERR1;
          else if (HWRITE) state_d = ST_DPHASE;
          else             state_d = ST_SETUP;
        end
      end
      ST_DPHASE: state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_pready)       state_d = sel_pslverr ? ST_ERR1 : ST_IDLE;
        else if (timeout_hit) state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    PENABLE   = 1'b0;
    psel_en   = 1'b0;
    case (state_q)
      ST_DPHASE: HREADYOUT = 1'b0;
      ST_SETUP: begin
        HREADYOUT = 1'b0;
        psel_en   = 1'b1;
      end
      ST_ACCESS: begin
        HREADYOUT = 1'b0;
        psel_en   = 1'b1;
        PENABLE   = 1'b1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2:   HRESP = 1'b1;
      default: ;
    endcase
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      PSEL[i] = psel_en && (idx_q == 4'(i));
  end

  // Address-phase fields are captured once at accept so they stay stable through ACCESS.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    idx_d    = idx_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    if (state_q == ST_IDLE && accept) begin
      paddr_d  = HADDR[PADDR_W-1:0];
      pwrite_d = HWRITE;
      idx_d    = idx_in;
    end
    if (state_q == ST_DPHASE)
      pwdata_d = HWDATA;
    if (state_q == ST_ACCESS && sel_pready && !sel_pslverr && !pwrite_q)
      hrdata_d = sel_prdata;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      idx_q    <= idx_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;
  assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_bfm_ahbl_apb_bridge_mc.sv
// Directed testbench for bfm_ahbl_apb_bridge_mc: a 16-slave instance for the main traffic
// and a 4-slave instance for out-of-range slot decoding.
module tb_bfm_ahbl_apb_bridge_mc;

   logic         hClk = 1'b0;
   logic         hReset;
   logic         hSel, hSel4;
   logic [31:0]  hAddr;
   logic         hWrite;
   logic [1:0]   hTrans;
   logic [2:0]   hSize;
   logic [31:0]  hWdata;
   logic         hReadyIn;

   logic [31:0]  hRdata;
   logic         hReadyOut, hResp;
   logic [7:0]   pAddr;
   logic [15:0]  pSel;
   logic         pEnable, pWrite;
   logic [31:0]  pWdata;
   logic [511:0] pRdata;
   logic [15:0]  pReady, pSlvErr;

   logic [31:0]  hRdata4;
   logic         hReadyOut4, hResp4;
   logic [7:0]   pAddr4;
   logic [3:0]   pSel4;
   logic         pEnable4, pWrite4;
   logic [31:0]  pWdata4;
   logic [127:0] pRdata4;
   logic [3:0]   pReady4, pSlvErr4;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waitCycles;
      logic        slvErr;
      logic [15:0] expPsel;
      logic [7:0]  expPaddr;
      int          expWaits;
      logic        expResp;
      logic [31:0] expHrdata;
   } vec_t;

   vec_t vecs[7];

   logic [15:0] obsPsel;
   logic [7:0]  obsPaddr;
   logic        obsPwrite;
   logic [31:0] obsPwdata;
   logic [31:0] obsHrdata;
   int          obsWaits;
   logic        obsResp;
   logic        obsErr1;
   logic        obsDone;

   // Free-running 100 MHz clock shared by both bridge instances.
   always #5 hClk = ~hClk;

   bfm_ahbl_apb_bridge_mc #(.NUM_SLAVES(16), .TIMEOUT_CYCLES(8)) dut (
      .HCLK(hClk), .HRESET(hReset), .HSEL(hSel), .HADDR(hAddr), .HWRITE(hWrite),
      .HTRANS(hTrans), .HSIZE(hSize), .HWDATA(hWdata), .HREADYIN(hReadyIn),
      .HRDATA(hRdata), .HREADYOUT(hReadyOut), .HRESP(hResp), .PADDR(pAddr),
      .PSEL(pSel), .PENABLE(pEnable), .PWRITE(pWrite), .PWDATA(pWdata),
      .PRDATA(pRdata), .PREADY(pReady), .PSLVERR(pSlvErr)
   );

   bfm_ahbl_apb_bridge_mc #(.NUM_SLAVES(4)) dut4 (
      .HCLK(hClk), .HRESET(hReset), .HSEL(hSel4), .HADDR(hAddr), .HWRITE(hWrite),
      .HTRANS(hTrans), .HSIZE(hSize), .HWDATA(hWdata), .HREADYIN(hReadyIn),
      .HRDATA(hRdata4), .HREADYOUT(hReadyOut4), .HRESP(hResp4), .PADDR(pAddr4),
      .PSEL(pSel4), .PENABLE(pEnable4), .PWRITE(pWrite4), .PWDATA(pWdata4),
      .PRDATA(pRdata4), .PREADY(pReady4), .PSLVERR(pSlvErr4)
   );

   // Single comparison point: every check bumps the counters used in the summary.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   // Runs one AHB transfer against the 16-slave bridge while acting as the APB slave.
   task automatic applyStimulus(input vec_t v);
      int idx;
      int accessCnt;
      idx       = int'(v.addr[11:8]);
      accessCnt = 0;
      obsPsel   = '0;
      obsPaddr  = '0;
      obsPwrite = 1'b0;
      obsPwdata = '0;
      obsWaits  = 0;
      obsResp   = 1'b0;
      obsErr1   = 1'b0;
      obsDone   = 1'b0;
      @(negedge hClk);
      for (int i = 0; i < 16; i++) pRdata[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
      pRdata[32*idx +: 32] = v.rdata;
      pReady       = '1;
      pSlvErr      = '0;
      pSlvErr[idx] = v.slvErr;
      if (v.waitCycles > 0) pReady[idx] = 1'b0;
      hSel     = 1'b1;
      hAddr    = v.addr;
      hWrite   = v.write;
      hTrans   = 2'b10;
      hSize    = v.size;
      hReadyIn = 1'b1;
      @(negedge hClk);
      hSel   = 1'b0;
      hTrans = 2'b00;
      hAddr  = 32'h0;
      hWdata = v.wdata;
      for (int c = 0; c < 64; c++) begin
         if (pSel != 16'h0 && !pEnable) begin
            obsPsel   = pSel;
            obsPaddr  = pAddr;
            obsPwrite = pWrite;
            obsPwdata = pWdata;
         end
         if (hReadyOut) begin
            obsResp   = hResp;
            obsHrdata = hRdata;
            obsDone   = 1'b1;
            break;
         end
         obsWaits++;
         if (hResp) obsErr1 = 1'b1;
         if (pEnable) begin
            accessCnt++;
            pReady[idx] = (accessCnt > v.waitCycles);
         end
         @(negedge hClk);
      end
   endtask

   initial begin
      // {write, addr, size, wdata, rdata, waits, slverr, psel, paddr, hready-low cycles, hresp, hrdata}
      vecs[0] = '{1'b1, 32'h0000_0204, 3'b010, 32'hA5A5_0001, 32'h0,          0, 1'b0, 16'h0004, 8'h04, 3, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 32'h0000_0F10, 3'b010, 32'h0,         32'hDEAD_BEEF, 4, 1'b0, 16'h8000, 8'h10, 6, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 32'h0000_0108, 3'b010, 32'h0,         32'h1111_2222, 0, 1'b1, 16'h0002, 8'h08, 3, 1'b1, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, 32'h0000_0300, 3'b011, 32'h5555_AAAA, 32'h0,          0, 1'b0, 16'h0000, 8'h00, 1, 1'b1, 32'hDEAD_BEEF};
      vecs[4] = '{1'b1, 32'h0000_07FC, 3'b010, 32'h7777_0007, 32'h0,          2, 1'b1, 16'h0080, 8'hFC, 6, 1'b1, 32'hDEAD_BEEF};
      vecs[5] = '{1'b0, 32'h0000_00AC, 3'b000, 32'h0,         32'h1234_5678, 1, 1'b0, 16'h0001, 8'hAC, 3, 1'b0, 32'h1234_5678};
      vecs[6] = '{1'b1, 32'h1234_093C, 3'b001, 32'h0F0F_F0F0, 32'h0,          0, 1'b0, 16'h0200, 8'h3C, 3, 1'b0, 32'h1234_5678};

      hReset   = 1'b1;
      hSel     = 1'b0;
      hSel4    = 1'b0;
      hAddr    = '0;
      hWrite   = 1'b0;
      hTrans   = 2'b00;
      hSize    = 3'b010;
      hWdata   = '0;
      hReadyIn = 1'b1;
      pRdata   = '0;
      pReady   = '1;
      pSlvErr  = '0;
      pRdata4  = '0;
      pReady4  = '1;
      pSlvErr4 = '0;

      repeat (2) @(negedge hClk);
      hReset = 1'b0;
      @(negedge hClk);
      checkOutput("rst_hreadyout", 32'(hReadyOut), 32'h1);
      checkOutput("rst_hresp",     32'(hResp),     32'h0);
      checkOutput("rst_psel",      32'(pSel),      32'h0);
      checkOutput("rst_penable",   32'(pEnable),   32'h0);
      checkOutput("rst_paddr",     32'(pAddr),     32'h0);
      checkOutput("rst_pwdata",    pWdata,         32'h0);
      checkOutput("rst_hrdata",    hRdata,         32'h0);

      for (int n = 0; n < 7; n++) begin
         applyStimulus(vecs[n]);
         checkOutput($sformatf("v%0d_done", n),  32'(obsDone),  32'h1);
         checkOutput($sformatf("v%0d_waits", n), 32'(obsWaits), 32'(vecs[n].expWaits));
         checkOutput($sformatf("v%0d_hresp", n), 32'(obsResp),  32'(vecs[n].expResp));
         checkOutput($sformatf("v%0d_err1", n),  32'(obsErr1),  32'(vecs[n].expResp));
         checkOutput($sformatf("v%0d_psel", n),  32'(obsPsel),  32'(vecs[n].expPsel));
         checkOutput($sformatf("v%0d_hrdata", n), obsHrdata,    vecs[n].expHrdata);
         if (vecs[n].expPsel != 16'h0) begin
            checkOutput($sformatf("v%0d_paddr", n),  32'(obsPaddr),  32'(vecs[n].expPaddr));
            checkOutput($sformatf("v%0d_pwrite", n), 32'(obsPwrite), 32'(vecs[n].write));
            if (vecs[n].write)
               checkOutput($sformatf("v%0d_pwdata", n), obsPwdata, vecs[n].wdata);
         end
      end

      // Back-to-back write then read to slot 0, second address phase in the completion cycle.
      @(negedge hClk);
      pReady = '1;
      pSlvErr = '0;
      pRdata[31:0] = 32'h0BB0_0001;
      hSel = 1'b1; hAddr = 32'h0000_0010; hWrite = 1'b1; hTrans = 2'b10; hSize = 3'b010;
      @(negedge hClk);
      hSel = 1'b0; hTrans = 2'b00; hWdata = 32'hCAFE_0010;
      @(negedge hClk);
      checkOutput("b2b_w_setup_psel", 32'(pSel), 32'h1);
      @(negedge hClk);
      checkOutput("b2b_w_access_penable", 32'(pEnable), 32'h1);
      @(negedge hClk);
      checkOutput("b2b_w_done_hreadyout", 32'(hReadyOut), 32'h1);
      checkOutput("b2b_w_pwdata", pWdata, 32'hCAFE_0010);
      hSel = 1'b1; hAddr = 32'h0000_0014; hWrite = 1'b0; hTrans = 2'b10;
      @(negedge hClk);
      hSel = 1'b0; hTrans = 2'b00;
      checkOutput("b2b_r_setup_psel",    32'(pSel),    32'h1);
      checkOutput("b2b_r_setup_penable", 32'(pEnable), 32'h0);
      checkOutput("b2b_r_setup_paddr",   32'(pAddr),   32'h14);
      checkOutput("b2b_r_setup_pwrite",  32'(pWrite),  32'h0);
      @(negedge hClk);
      checkOutput("b2b_r_access_penable", 32'(pEnable), 32'h1);
      @(negedge hClk);
      checkOutput("b2b_r_done_hreadyout", 32'(hReadyOut), 32'h1);
      checkOutput("b2b_r_hrdata", hRdata, 32'h0BB0_0001);

      // BUSY and IDLE transfers must complete immediately with OKAY.
      hSel = 1'b1; hAddr = 32'h0000_0300; hWrite = 1'b1; hTrans = 2'b01;
      @(negedge hClk);
      checkOutput("busy_hreadyout", 32'(hReadyOut), 32'h1);
      checkOutput("busy_psel",      32'(pSel),      32'h0);
      checkOutput("busy_hresp",     32'(hResp),     32'h0);
      hTrans = 2'b00;
      @(negedge hClk);
      checkOutput("idle_hreadyout", 32'(hReadyOut), 32'h1);
      hSel = 1'b0;

      // Four-slave instance: slot 5 is out of range, slot 3 is the last legal one.
      hSel4 = 1'b1; hAddr = 32'h0000_0500; hWrite = 1'b0; hTrans = 2'b10; hSize = 3'b010;
      @(negedge hClk);
      hSel4 = 1'b0; hTrans = 2'b00;
      checkOutput("s4_err1_hreadyout", 32'(hReadyOut4), 32'h0);
      checkOutput("s4_err1_hresp",     32'(hResp4),     32'h1);
      checkOutput("s4_err1_psel",      32'(pSel4),      32'h0);
      @(negedge hClk);
      checkOutput("s4_err2_hreadyout", 32'(hReadyOut4), 32'h1);
      checkOutput("s4_err2_hresp",     32'(hResp4),     32'h1);
      checkOutput("s4_err2_psel",      32'(pSel4),      32'h0);
      @(negedge hClk);
      checkOutput("s4_idle_hresp", 32'(hResp4), 32'h0);
      hSel4 = 1'b1; hAddr = 32'h0000_0320; hTrans = 2'b10;
      @(negedge hClk);
      hSel4 = 1'b0; hTrans = 2'b00;
      checkOutput("s4_slot3_psel", 32'(pSel4), 32'h8);
      repeat (2) @(negedge hClk);
      checkOutput("s4_slot3_done", 32'(hReadyOut4), 32'h1);

`ifdef APB_TIMEOUT_EN
      // Slot 4 never answers; the bridge gives up after TIMEOUT_CYCLES ACCESS cycles.
      begin
         int accessCnt;
         logic sawErr;
         accessCnt = 0;
         sawErr = 1'b0;
         pReady = '1;
         pReady[4] = 1'b0;
         hSel = 1'b1; hAddr = 32'h0000_0400; hWrite = 1'b0; hTrans = 2'b10;
         @(negedge hClk);
         hSel = 1'b0; hTrans = 2'b00;
         for (int c = 0; c < 40; c++) begin
            if (pEnable) accessCnt++;
            if (!hReadyOut && hResp) begin
               sawErr = 1'b1;
               break;
            end
            @(negedge hClk);
         end
         checkOutput("tmo_err1_seen", 32'(sawErr), 32'h1);
         checkOutput("tmo_access_cycles", 32'(accessCnt), 32'd8);
         checkOutput("tmo_err1_psel", 32'(pSel), 32'h0);
         @(negedge hClk);
         checkOutput("tmo_err2_hresp", 32'(hResp), 32'h1);
         checkOutput("tmo_hrdata", hRdata, 32'h0BB0_0001);
         pReady = '1;
         @(negedge hClk);
      end
`endif

      // Reset during ACCESS drops the APB handshake at once and loses the transfer.
      pReady = '1;
      pReady[3] = 1'b0;
      hSel = 1'b1; hAddr = 32'h0000_0300; hWrite = 1'b0; hTrans = 2'b10;
      @(negedge hClk);
      hSel = 1'b0; hTrans = 2'b00;
      @(negedge hClk);
      checkOutput("rstmid_access_penable", 32'(pEnable), 32'h1);
      #1 hReset = 1'b1;
      #1;
      checkOutput("rstmid_psel",      32'(pSel),      32'h0);
      checkOutput("rstmid_penable",   32'(pEnable),   32'h0);
      checkOutput("rstmid_hreadyout", 32'(hReadyOut), 32'h1);
      @(negedge hClk);
      hReset = 1'b0;
      pReady = '1;
      @(negedge hClk);
      checkOutput("rstmid_after_psel",      32'(pSel),      32'h0);
      checkOutput("rstmid_after_hreadyout", 32'(hReadyOut), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case a sequence above ever stalls.
   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
